// File: rtl/aes_round_sched.sv
// ---------------------------------------------------------------------------
// aes_round_sched
// Iterative AES encryption sequencer. Accepts one 128-bit block per
// valid/ready handshake and runs one round per clock through an external
// combinational single-round datapath. It picks the round key out of the
// captured expanded-key vector and recirculates the state until the
// requested number of rounds (10, 12 or 14) has been run.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready input block handshake
//   in_data           plaintext block
//   in_nr             round count for this block (10, 12 or 14)
//   in_expanded_key   15 x 128b round keys, round key 0 at the MSBs
//   rd_state/rd_key   state and round key presented to the round datapath
//   rd_last           current round is the final one (no MixColumns)
//   rd_result         combinational round datapath result
//   round_cnt         current round number, 0 when not running rounds
//   out_valid/ready   ciphertext handshake
//   out_data          ciphertext (0 for a rejected block)
//   out_err           qualifies out_valid: block had an illegal round count
// ---------------------------------------------------------------------------
module aes_round_sched #(
  parameter int KEY_BITS = 1920,
  parameter int MAX_NR   = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [3:0]          in_nr,
  input  logic [KEY_BITS-1:0] in_expanded_key,
  output logic [127:0]        rd_state,
  output logic [127:0]        rd_key,
  output logic                rd_last,
  input  logic [127:0]        rd_result,
  output logic [3:0]          round_cnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                out_err
);

  localparam int NUM_RK = MAX_NR + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  fsm_t fsm_reg;
  fsm_t fsm_next;

  logic [127:0] state_reg;
  logic [3:0]   nr_reg;
  logic [3:0]   round_reg;
  logic [127:0] out_data_reg;
  logic         out_err_reg;
  logic [127:0] hold_state_reg;
  logic [127:0] hold_key_reg;
  logic [127:0] rk_reg [NUM_RK];

  logic [127:0] in_rk [NUM_RK];
  logic [127:0] cur_key;
  logic         accept;
  logic         nr_legal;
  logic         final_round;

  // Slice the incoming expanded key into round keys; round key r sits
  // 128*r bits below the top of the vector.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RK; gi++) begin : g_in_rk
      assign in_rk[gi] = in_expanded_key[KEY_BITS-1-128*gi -: 128];
    end
  endgenerate

  assign accept      = in_valid & in_ready;
  assign nr_legal    = ((in_nr == 4'd10) || (in_nr == 4'd12) || (in_nr == 4'd14))
                       && (int'(in_nr) <= MAX_NR);
  assign final_round = (round_reg == nr_reg);

  // Round-key select from the captured copy. The counter never leaves
  // 0..nr_reg, so the zero default is never reached in normal operation.
  always_comb begin
    cur_key = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (round_reg == 4'(i)) begin
        cur_key = rk_reg[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg <= S_IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      S_IDLE: begin
        if (accept) begin
          // An illegal round count skips straight to the output stage.
          fsm_next = nr_legal ? S_ROUND : S_DONE;
        end
      end
      S_ROUND: begin
        if (final_round) begin
          fsm_next = S_DONE;
        end
      end
      S_DONE: begin
        // A new block is never taken in this cycle, even if in_valid is
        // high: it is accepted from IDLE on the following edge.
        if (out_ready) begin
          fsm_next = S_IDLE;
        end
      end
      default: fsm_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (fsm_reg == S_IDLE) && !rst;
    out_valid = (fsm_reg == S_DONE);
    rd_last   = (fsm_reg == S_ROUND) && final_round;
    if (fsm_reg == S_ROUND) begin
      rd_state = state_reg;
      rd_key   = cur_key;
    end else begin
      // Outside ROUND the datapath inputs keep the values of the last round.
      rd_state = hold_state_reg;
      rd_key   = hold_key_reg;
    end
  end

  assign round_cnt = round_reg;
  assign out_data  = out_data_reg;
  assign out_err   = out_err_reg;

  // -------------------------------------------------------------------------
  // Block parameters captured on acceptance, so later changes on in_nr and
  // in_expanded_key cannot disturb the block in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      nr_reg <= '0;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_reg[i] <= '0;
      end
    end else if (accept) begin
      nr_reg <= in_nr;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_reg[i] <= in_rk[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: state, round counter, result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= '0;
      round_reg      <= '0;
      out_data_reg   <= '0;
      out_err_reg    <= 1'b0;
      hold_state_reg <= '0;
      hold_key_reg   <= '0;
    end else begin
      case (fsm_reg)
        S_IDLE: begin
          if (accept) begin
            if (nr_legal) begin
              // Round 0 AddRoundKey is folded into the load.
              state_reg   <= in_data ^ in_rk[0];
              round_reg   <= 4'd1;
              out_err_reg <= 1'b0;
            end else begin
              out_data_reg <= '0;
              out_err_reg  <= 1'b1;
            end
          end
        end
        S_ROUND: begin
          state_reg      <= rd_result;
          hold_state_reg <= state_reg;
          hold_key_reg   <= cur_key;
          if (final_round) begin
            out_data_reg <= rd_result;
            round_reg    <= 4'd0;
          end else begin
            round_reg <= round_reg + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_err_reg <= 1'b0;
          end
        end
        default: begin
          round_reg <= 4'd0;
        end
      endcase
    end
  end

endmodule
